// File: rtl/tod_bcd_arbiter.sv
// -----------------------------------------------------------------------------
// tod_bcd_arbiter
//
// Round-robin arbiter that shares one binary-to-BCD converter between the
// time-of-day field requesters (seconds, minutes, hours, day-of-year).
// A granted requester's binary field is latched and handed to the converter.
// The block then waits for the converter's done level, or gives up after
// TIMEOUT cycles, and returns the result with a one-hot acknowledge.
//
// Ports
//   i_Clock         sole clock, rising edge
//   i_Reset         asynchronous active-high reset
//   i_Req           per-requester request level
//   i_Binary        packed binary fields, requester k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   o_Ack           one-cycle one-hot completion pulse
//   o_BCD           result, valid with o_Ack and held until the next o_Ack
//   o_Err           one-cycle pulse with o_Ack when the converter timed out
//   o_Busy          high whenever the FSM is not idle
//   o_Conv_Start    one-cycle start pulse to the converter
//   o_Conv_Binary   operand to the converter, stable for the whole transaction
//   o_Conv_Clear    one-cycle re-arm pulse to the converter
//   i_Conv_BCD      converter result
//   i_Conv_DV       converter done level, held until o_Conv_Clear
// -----------------------------------------------------------------------------
module tod_bcd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int INPUT_WIDTH    = 9,
    parameter int DECIMAL_DIGITS = 3,
    parameter int TIMEOUT        = 256
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic [NUM_REQ-1:0]            i_Req,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Binary,
    output logic [NUM_REQ-1:0]            o_Ack,
    output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
    output logic                          o_Err,
    output logic                          o_Busy,
    output logic                          o_Conv_Start,
    output logic [INPUT_WIDTH-1:0]        o_Conv_Binary,
    output logic                          o_Conv_Clear,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_Conv_BCD,
    input  logic                          i_Conv_DV
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_CLEAR
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        rr_ptr_q;
    logic [PTR_W-1:0]        grant_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    timeout_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [INPUT_WIDTH-1:0]  conv_bin_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic                    start_q;
    logic                    clear_q;
    logic                    busy_q;

    logic [PTR_W-1:0]        grant_d;
    logic                    grant_vld_d;
    logic [PTR_W-1:0]        rr_ptr_d;
    logic [INPUT_WIDTH-1:0]  field_arr [NUM_REQ];

    // Unpack the requester fields so the granted one can be picked by index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_field
            assign field_arr[gi] = i_Binary[gi*INPUT_WIDTH +: INPUT_WIDTH];
        end
    endgenerate

    // Rotating priority search: first pending requester at or above rr_ptr,
    // wrapping around past the top index.
    always_comb begin : grant_search
        int               cand;
        logic [PTR_W-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_vld_d = 1'b0;
        grant_d     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_vld_d && i_Req[cand_idx]) begin
                grant_vld_d = 1'b1;
                grant_d     = cand_idx;
            end
        end
    end

    assign rr_ptr_d = (grant_d == PTR_W'(NUM_REQ - 1)) ? '0 : grant_d + 1'b1;

    // Outputs are registered: each pulse is set on the edge that enters the
    // state it belongs to, so it is high for exactly that state's cycle.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
            bcd_q      <= '0;
            conv_bin_q <= '0;
            ack_q      <= '0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            clear_q <= 1'b0;
            ack_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld_d) begin
                        grant_q    <= grant_d;
                        conv_bin_q <= field_arr[grant_d];
                        rr_ptr_q   <= rr_ptr_d;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_Conv_DV) begin
                        bcd_q   <= i_Conv_BCD;
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= ST_CAPTURE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Converter never answered: report all-ones with an error.
                        bcd_q     <= '1;
                        ack_q     <= NUM_REQ'(1) << grant_q;
                        timeout_q <= 1'b1;
                        state_q   <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    timeout_q <= 1'b0;
                    clear_q   <= 1'b1;
                    state_q   <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Ack         = ack_q;
    assign o_BCD         = bcd_q;
    assign o_Err         = timeout_q;
    assign o_Busy        = busy_q;
    assign o_Conv_Start  = start_q;
    assign o_Conv_Binary = conv_bin_q;
    assign o_Conv_Clear  = clear_q;

endmodule

// File: tb/tb_tod_bcd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tod_bcd_arbiter
//
// Drives the arbiter with directed and random request traffic against a
// behavioural converter model. A reference model computes the expected
// round-robin grant order and decimal result for every transaction. A second
// instance with a short timeout and a silent converter covers the error path.
// -----------------------------------------------------------------------------
module tb_tod_bcd_arbiter;

    localparam int N = 4;
    localparam int W = 9;
    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   bin;
    logic [N-1:0]     ack;
    logic [D*4-1:0]   bcd;
    logic             err;
    logic             busy;
    logic             cstart;
    logic [W-1:0]     cbin;
    logic             cclear;
    logic [D*4-1:0]   conv_bcd;
    logic             conv_dv;

    logic [N-1:0]     t_req;
    logic [N*W-1:0]   t_bin;
    logic [N-1:0]     t_ack;
    logic [D*4-1:0]   t_bcd;
    logic             t_err;
    logic             t_busy;
    logic             t_start;
    logic [W-1:0]     t_cbin;
    logic             t_clear;
    logic [D*4-1:0]   t_conv_bcd;
    logic             t_conv_dv;

    tod_bcd_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .DECIMAL_DIGITS(D), .TIMEOUT(256)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req), .i_Binary(bin),
        .o_Ack(ack), .o_BCD(bcd), .o_Err(err), .o_Busy(busy),
        .o_Conv_Start(cstart), .o_Conv_Binary(cbin), .o_Conv_Clear(cclear),
        .i_Conv_BCD(conv_bcd), .i_Conv_DV(conv_dv)
    );

    tod_bcd_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .DECIMAL_DIGITS(D), .TIMEOUT(16)) dut_to (
        .i_Clock(clk), .i_Reset(rst), .i_Req(t_req), .i_Binary(t_bin),
        .o_Ack(t_ack), .o_BCD(t_bcd), .o_Err(t_err), .o_Busy(t_busy),
        .o_Conv_Start(t_start), .o_Conv_Binary(t_cbin), .o_Conv_Clear(t_clear),
        .i_Conv_BCD(t_conv_bcd), .i_Conv_DV(t_conv_dv)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int         g;
        logic [11:0] val;
    } exp_t;

    exp_t           expq[$];
    int             ack_log[$];
    int             ptr        = 0;
    int             cyc        = 0;
    int             last_start = -100;
    int             n_starts   = 0;
    logic [W-1:0]   exp_op     = '0;

    // Converter model state
    int             ccnt       = 0;
    logic [W-1:0]   cop        = '0;
    bit             rand_delay = 0;
    int             dv_cyc     = 0;
    bit             lat_armed  = 0;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        expq.delete();
        ptr        = 0;
        last_start = -100;
        ccnt       = 0;
        conv_dv    = 1'b0;
        lat_armed  = 0;
    endtask

    // One clock of observation at the falling edge, then the converter model.
    task automatic tick();
        int g;
        exp_t e;
        @(negedge clk);
        cyc++;
        if (ack !== '0) begin
            for (int k = 0; k < N; k++) if (ack[k]) ack_log.push_back(k);
            if (expq.size() == 0) begin
                chk("spurious_ack", 64'(ack), 64'(0));
            end else begin
                e = expq.pop_front();
                chk("ack_onehot", 64'(ack), 64'(1) << e.g);
                chk("ack_bcd", 64'(bcd), 64'(e.val));
                chk("ack_err", 64'(err), 64'(0));
                chk("conv_binary_hold", 64'(cbin), 64'(exp_op));
            end
        end
        if (cstart === 1'b1) begin
            n_starts++;
            chk("start_gap_ge5", 64'((cyc - last_start) >= 5), 64'(1));
            last_start = cyc;
            g = pick(req, ptr);
            chk("grant_has_req", 64'(g >= 0), 64'(1));
            if (g >= 0) begin
                exp_op = bin[g*W +: W];
                chk("conv_binary", 64'(cbin), 64'(exp_op));
                e.g   = g;
                e.val = to_bcd(int'(exp_op));
                expq.push_back(e);
                ptr = (g + 1) % N;
            end
        end
        if (lat_armed && busy === 1'b0) begin
            chk("dv_to_idle", 64'(cyc - dv_cyc), 64'(3));
            lat_armed = 0;
        end
        if (cclear === 1'b1) conv_dv = 1'b0;
        if (cstart === 1'b1) begin
            cop  = cbin;
            ccnt = rand_delay ? int'($urandom_range(1, 30)) : 20;
        end else if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) begin
                conv_dv   = 1'b1;
                conv_bcd  = to_bcd(int'(cop));
                dv_cyc    = cyc;
                lat_armed = 1;
            end
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        for (int i = 0; i < budget && ack_log.size() < target; i++) tick();
        chk("ack_count", 64'(ack_log.size()), 64'(target));
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget && n_starts < target; i++) tick();
        chk("start_count", 64'(n_starts), 64'(target));
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (busy !== 1'b0 || expq.size() != 0); i++) tick();
        chk("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy),   64'(0));
        chk({tag, "_ack"},   64'(ack),    64'(0));
        chk({tag, "_bcd"},   64'(bcd),    64'(0));
        chk({tag, "_cbin"},  64'(cbin),   64'(0));
        chk({tag, "_start"}, 64'(cstart), 64'(0));
        chk({tag, "_clear"}, 64'(cclear), 64'(0));
        chk({tag, "_err"},   64'(err),    64'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int s, a, clears;
        logic [N-1:0]   t_ack_seen;
        logic [D*4-1:0] t_bcd_seen;
        logic           t_err_seen;

        rst        = 1'b1;
        req        = '0;
        bin        = '0;
        conv_dv    = 1'b0;
        conv_bcd   = '0;
        t_req      = '0;
        t_bin      = '0;
        t_conv_bcd = '0;
        t_conv_dv  = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        chk("reset_to_busy", 64'(t_busy), 64'(0));
        chk("reset_to_bcd",  64'(t_bcd),  64'(0));
        rst = 1'b0;

        // Single request: seconds = 59
        bin[0*W +: W] = 9'd59;
        req = 4'b0001;
        wait_starts(1, 50);
        req = '0;
        wait_acks(1, 100);
        if (ack_log.size() > 0) chk("first_ack_idx", 64'(ack_log[0]), 64'(0));
        wait_idle(20);

        // All four held: round-robin order 0,1,2,3,0 from a fresh reset
        do_reset();
        ack_log.delete();
        n_starts = 0;
        bin = {9'd366, 9'd23, 9'd45, 9'd59};
        req = 4'b1111;
        wait_starts(5, 400);
        req = '0;
        wait_acks(5, 100);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            chk($sformatf("rr_order_%0d", i), 64'(ack_log[i]), 64'(exp_order[i]));
        wait_idle(20);

        // Requester 2 drops its request and changes its field after grant
        ack_log.delete();
        n_starts = 0;
        bin[2*W +: W] = 9'd123;
        req = 4'b0100;
        wait_starts(1, 50);
        req = '0;
        bin[2*W +: W] = 9'd77;
        wait_acks(1, 100);
        if (ack_log.size() > 0) chk("drop_ack_idx", 64'(ack_log[0]), 64'(2));
        wait_idle(20);

        // Reset pulsed while waiting on the converter
        ack_log.delete();
        n_starts = 0;
        bin[0*W +: W] = 9'd12;
        req = 4'b0001;
        wait_starts(1, 50);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        bin[1*W +: W] = 9'd31;
        bin[3*W +: W] = 9'd200;
        req = 4'b1010;
        n_starts = 0;
        wait_starts(1, 50);
        req = '0;
        wait_acks(1, 100);
        if (ack_log.size() > 0) chk("post_reset_first_grant", 64'(ack_log[0]), 64'(1));
        wait_idle(20);

        // Random traffic with random converter latency
        rand_delay = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 2) == 0) bin[$urandom_range(0, N-1)*W +: W] = W'($urandom_range(0, 511));
            tick();
        end
        req = '0;
        wait_idle(200);
        chk("queue_drained", 64'(expq.size()), 64'(0));

        // Timeout path on the instance whose converter never answers
        s = -1;
        a = -1;
        clears = 0;
        t_ack_seen = '0;
        t_bcd_seen = '0;
        t_err_seen = 1'b0;
        t_bin[0*W +: W] = 9'd5;
        t_req = 4'b0001;
        for (int tc = 0; tc < 40; tc++) begin
            @(negedge clk);
            if (t_start === 1'b1 && s < 0) begin
                s = tc;
                t_req = '0;
            end
            if (t_ack !== '0) begin
                a = tc;
                t_ack_seen = t_ack;
                t_bcd_seen = t_bcd;
                t_err_seen = t_err;
            end
            if (t_clear === 1'b1) clears++;
        end
        chk("timeout_latency", 64'(a - s), 64'(17));
        chk("timeout_ack", 64'(t_ack_seen), 64'(1));
        chk("timeout_bcd", 64'(t_bcd_seen), 64'(12'hFFF));
        chk("timeout_err", 64'(t_err_seen), 64'(1));
        chk("timeout_clears", 64'(clears), 64'(1));
        chk("timeout_idle", 64'(t_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tod_bcd_arbiter.md
TOD_BCD_ARBITER -- requirements
Module: tod_bcd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters (seconds, minutes, hours, day-of-year).
REQ-002 Parameter INPUT_WIDTH, default 9, is the binary field width per requester.
REQ-003 Parameter DECIMAL_DIGITS, default 3, is the BCD digit count of the shared converter.
REQ-004 Parameter TIMEOUT, default 256, is the maximum number of cycles spent waiting for converter done.
REQ-005 Port i_Clock  in  1  sole clock; all logic is on the rising edge.
REQ-006 Port i_Reset  in  1  asynchronous, active-high reset.
REQ-007 Port i_Req  in  NUM_REQ  per-requester conversion request level.
REQ-008 Port i_Binary  in  NUM_REQ*INPUT_WIDTH  requester k's value is in bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-009 Port o_Ack  out  NUM_REQ  one-cycle, one-hot completion pulse to the granted requester.
REQ-010 Port o_BCD  out  DECIMAL_DIGITS*4  result; valid in the o_Ack cycle and held until the next o_Ack.
REQ-011 Port o_Err  out  1  one-cycle pulse coincident with o_Ack when the conversion timed out.
REQ-012 Port o_Busy  out  1  high in every state except IDLE.
REQ-013 Port o_Conv_Start  out  1  one-cycle start pulse to the shared converter.
REQ-014 Port o_Conv_Binary  out  INPUT_WIDTH  operand to the converter.
REQ-015 Port o_Conv_Clear  out  1  one-cycle re-arm pulse to the converter after every transaction.
REQ-016 Port i_Conv_BCD  in  DECIMAL_DIGITS*4  converter result.
REQ-017 Port i_Conv_DV  in  1  converter done level; stays high until o_Conv_Clear.

Function
REQ-018 The FSM SHALL have five states: IDLE, START, WAIT, CAPTURE, CLEAR.
REQ-019 IDLE: if any i_Req bit is high, the block SHALL grant the first requester at or above rr_ptr (with wrap-around), latch that requester's i_Binary into o_Conv_Binary, set rr_ptr to grant+1 mod NUM_REQ, and go to START.
REQ-020 START: o_Conv_Start SHALL be high for exactly this cycle and the wait counter SHALL clear; next state is WAIT.
REQ-021 o_Conv_Binary SHALL remain stable from START until IDLE is re-entered.
REQ-022 WAIT: when i_Conv_DV is high, the FSM SHALL go to CAPTURE; otherwise the counter SHALL increment, and when it reaches TIMEOUT-1 the FSM SHALL go to CAPTURE with a timeout flag set.
REQ-023 CAPTURE, normal case: the block SHALL register o_BCD <= i_Conv_BCD and pulse o_Ack[grant].
REQ-024 CAPTURE, timeout case: the block SHALL set o_BCD to all ones, pulse o_Ack[grant], and pulse o_Err.
REQ-025 After CAPTURE, the FSM SHALL go to CLEAR, where o_Conv_Clear SHALL be high for one cycle; next state is IDLE.
REQ-026 Requests SHALL be sampled only in IDLE; dropping i_Req after grant SHALL NOT abort the transaction, and o_Ack is still issued.
REQ-027 A requester holding i_Req high after its o_Ack SHALL be re-served only after all other pending requesters (round-robin fairness).
REQ-028 Latency SHALL be exactly 3 cycles from the first i_Conv_DV-high cycle to the return to IDLE (CAPTURE, then CLEAR, then IDLE).
REQ-029 The minimum gap between two grants SHALL be 5 cycles.
REQ-030 i_Conv_DV asserted during IDLE, START or CLEAR SHALL be ignored.

Reset
REQ-031 While i_Reset is high, the block SHALL immediately hold state IDLE, rr_ptr=0, counter=0, timeout flag=0, o_BCD=0, o_Conv_Binary=0, and all pulse outputs and o_Busy at 0, independent of the clock.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no o_Ack.
REQ-033 After reset deassertion, the first grant SHALL go to the lowest-index pending requester.

Verification
REQ-034 Bench converter model returns the BCD of its operand 20 cycles after start: i_Req=0001, field0=59 -> o_BCD=0x059, o_Ack=0001, o_Err=0.
REQ-035 i_Req=1111 held, fields 59/45/23/366 -> acks in order 0,1,2,3,0, each paired with 0x059/0x045/0x023/0x366.
REQ-036 Converter model never asserts DV, TIMEOUT=16 -> o_Ack after 16 WAIT cycles, o_BCD=0xFFF, o_Err=1, o_Conv_Clear pulses once.
REQ-037 Reset pulsed during WAIT -> no o_Ack, o_Busy=0 immediately; the next request is served normally.
REQ-038 Requester 2 drops i_Req the cycle after grant -> o_Ack[2] still pulses with correct BCD; i_Binary changed after grant -> o_Conv_Binary unchanged.
